// File: rtl/mem_rmw_if.sv
// Request/response bundle between the arbiter+RAM side (master) and mem_rmw_unit (slave).
interface mem_rmw_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic              i_valid;
  logic              i_wr;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] o_rdata;
  logic              o_stall;
  logic              o_misalign;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic              o_ram_wr;
  logic [DATA_W-1:0] i_ram_rdata;

  modport slave (
    input  i_valid, i_wr, i_size, i_unsigned, i_addr, i_wdata, i_ram_rdata,
    output o_rdata, o_stall, o_misalign, o_ram_addr, o_ram_wdata, o_ram_wr
  );

  // Master side covers both the arbiter requests and the RAM read data.
  modport master (
    output i_valid, i_wr, i_size, i_unsigned, i_addr, i_wdata, i_ram_rdata,
    input  o_rdata, o_stall, o_misalign, o_ram_addr, o_ram_wdata, o_ram_wr
  );
endinterface

// File: rtl/mem_rmw_unit.sv
// Memory access stage: sub-word store read-modify-write, load alignment, misalignment flagging.
// Optional macro MEM_RMW_LOAD_EXT_EN enables load lane extraction/extension; otherwise raw words.
module mem_rmw_unit #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  mem_rmw_if.slave  bus
);

  localparam int unsigned WA_W = ADDR_W - 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MERGE = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        off_q,   off_d;
  logic [1:0]        size_q,  size_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;

  logic              is_half, is_word, misalign;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_word;

  assign is_half  = (bus.i_size == SZ_HALF);
  assign is_word  = bus.i_size[1];
  assign misalign = (is_half && bus.i_addr[0]) || (is_word && (bus.i_addr[1:0] != 2'b00));

  // Load lane extraction and extension.
  always_comb begin
    load_data = bus.i_ram_rdata;
`ifdef MEM_RMW_LOAD_EXT_EN
    begin
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      case (bus.i_addr[1:0])
        2'd0:    byte_sel = bus.i_ram_rdata[7:0];
        2'd1:    byte_sel = bus.i_ram_rdata[15:8];
        2'd2:    byte_sel = bus.i_ram_rdata[23:16];
        default: byte_sel = bus.i_ram_rdata[31:24];
      endcase
      half_sel = bus.i_addr[1] ? bus.i_ram_rdata[31:16] : bus.i_ram_rdata[15:0];
      case (bus.i_size)
        SZ_BYTE: load_data = {{24{~bus.i_unsigned & byte_sel[7]}}, byte_sel};
        SZ_HALF: load_data = {{16{~bus.i_unsigned & half_sel[15]}}, half_sel};
        default: load_data = bus.i_ram_rdata;
      endcase
    end
`endif
  end

  // Replace only the addressed lane(s) of the captured RAM word.
  always_comb begin
    merge_word = merge_q;
    if (size_q == SZ_HALF) begin
      if (off_q[1]) merge_word[31:16] = wdata_q;
      else          merge_word[15:0]  = wdata_q;
    end else begin
      case (off_q)
        2'd0:    merge_word[7:0]   = wdata_q[7:0];
        2'd1:    merge_word[15:8]  = wdata_q[7:0];
        2'd2:    merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Next-state and output decode; every output is held at 0 while reset is low.
  always_comb begin
    state_d         = state_q;
    merge_d         = merge_q;
    wdata_d         = wdata_q;
    off_d           = off_q;
    size_d          = size_q;
    waddr_d         = waddr_q;
    bus.o_rdata     = '0;
    bus.o_stall     = 1'b0;
    bus.o_misalign  = 1'b0;
    bus.o_ram_addr  = '0;
    bus.o_ram_wdata = '0;
    bus.o_ram_wr    = 1'b0;

    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          bus.o_ram_addr = {bus.i_addr[ADDR_W-1:2], 2'b00};
          if (bus.i_valid) begin
            if (misalign) begin
              bus.o_misalign = 1'b1;
            end else if (bus.i_wr) begin
              if (is_word) begin
                bus.o_ram_wr    = 1'b1;
                bus.o_ram_wdata = bus.i_wdata;
              end else begin
                bus.o_stall = 1'b1;
                merge_d     = bus.i_ram_rdata;
                wdata_d     = bus.i_wdata[15:0];
                off_d       = bus.i_addr[1:0];
                size_d      = bus.i_size;
                waddr_d     = bus.i_addr[ADDR_W-1:2];
                state_d     = ST_MERGE;
              end
            end else begin
              bus.o_rdata = load_data;
            end
          end
        end
        ST_MERGE: begin
          bus.o_ram_addr  = {waddr_q, 2'b00};
          bus.o_ram_wr    = 1'b1;
          bus.o_ram_wdata = merge_word;
          state_d         = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      merge_q <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      waddr_q <= waddr_d;
    end
  end

endmodule

// File: tb/tb_mem_rmw_unit.sv
// Directed bench for mem_rmw_unit: single-cycle vector table plus RMW and reset sequences.
module tb_mem_rmw_unit;

`ifdef MEM_RMW_LOAD_EXT_EN
  localparam bit LOAD_EXT = 1'b1;
`else
  localparam bit LOAD_EXT = 1'b0;
`endif

  localparam logic [31:0] LD_WORD = 32'h80F07F01;

  logic clk;
  logic reset;
  logic [31:0] mem [0:2047];
  int checks;
  int failures;

  mem_rmw_if #(.ADDR_W(13), .DATA_W(32)) bus ();

  mem_rmw_unit #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.i_ram_rdata = mem[bus.o_ram_addr[12:2]];

  always @(posedge clk) begin
    if (bus.o_ram_wr) mem[bus.o_ram_addr[12:2]] <= bus.o_ram_wdata;
  end

  typedef struct {
    string       name;
    logic        v;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [12:0] addr;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_st;
    logic        e_mis;
    logic        e_wr;
    logic [31:0] e_wd;
    logic [12:0] e_ra;
  } vec_t;

  function automatic vec_t mk(string n, logic v, logic wr, logic [1:0] sz, logic uns,
                              logic [12:0] a, logic [31:0] wd, logic [31:0] erd,
                              logic est, logic emis, logic ewr, logic [31:0] ewd,
                              logic [12:0] era);
    vec_t t;
    t.name = n; t.v = v; t.wr = wr; t.sz = sz; t.uns = uns; t.addr = a; t.wd = wd;
    t.e_rd = erd; t.e_st = est; t.e_mis = emis; t.e_wr = ewr; t.e_wd = ewd; t.e_ra = era;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, logic wr, logic [1:0] sz, logic uns, logic [12:0] a, logic [31:0] wd);
    bus.i_valid    = v;
    bus.i_wr       = wr;
    bus.i_size     = sz;
    bus.i_unsigned = uns;
    bus.i_addr     = a;
    bus.i_wdata    = wd;
  endtask

  task automatic sw(logic [12:0] a, logic [31:0] wd);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b10, 1'b0, a, wd);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 13'h0, 32'h0);
  endtask

  // Sub-word store: stall cycle, then merged write; optionally scramble inputs during MERGE.
  task automatic sub_store(string nm, logic [1:0] sz, logic [12:0] a, logic [31:0] wd,
                           logic [31:0] exp, bit scramble);
    logic [12:0] wa;
    wa = {a[12:2], 2'b00};
    @(negedge clk);
    drive(1'b1, 1'b1, sz, 1'b0, a, wd);
    #1;
    chk({nm, "_stall1"}, 32'(bus.o_stall), 32'd1);
    chk({nm, "_wr1"},    32'(bus.o_ram_wr), 32'd0);
    chk({nm, "_mis1"},   32'(bus.o_misalign), 32'd0);
    @(negedge clk);
    if (scramble) drive(1'b1, 1'b0, 2'b10, 1'b1, 13'h1FFC, 32'hFFFFFFFF);
    #1;
    chk({nm, "_stall2"}, 32'(bus.o_stall), 32'd0);
    chk({nm, "_wr2"},    32'(bus.o_ram_wr), 32'd1);
    chk({nm, "_wdata"},  bus.o_ram_wdata, exp);
    chk({nm, "_raddr"},  32'(bus.o_ram_addr), 32'(wa));
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 13'h0, 32'h0);
    #1;
    chk({nm, "_mem"}, mem[wa[12:2]], exp);
  endtask

  vec_t vecs[18];

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = mk("sw_020",    1, 1, 2'b10, 0, 13'h020, 32'hDEADBEEF, 32'h0, 0, 0, 1, 32'hDEADBEEF, 13'h020);
    vecs[1]  = mk("sw_030",    1, 1, 2'b10, 0, 13'h030, LD_WORD,      32'h0, 0, 0, 1, LD_WORD,      13'h030);
    vecs[2]  = mk("sw_010",    1, 1, 2'b10, 0, 13'h010, 32'hAABBCCDD, 32'h0, 0, 0, 1, 32'hAABBCCDD, 13'h010);
    vecs[3]  = mk("sw_008",    1, 1, 2'b10, 0, 13'h008, 32'h11223344, 32'h0, 0, 0, 1, 32'h11223344, 13'h008);
    vecs[4]  = mk("lb_032",    1, 0, 2'b00, 0, 13'h032, 32'h0, LOAD_EXT ? 32'hFFFFFFF0 : LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[5]  = mk("lbu_032",   1, 0, 2'b00, 1, 13'h032, 32'h0, LOAD_EXT ? 32'h000000F0 : LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[6]  = mk("lh_032",    1, 0, 2'b01, 0, 13'h032, 32'h0, LOAD_EXT ? 32'hFFFF80F0 : LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[7]  = mk("lhu_032",   1, 0, 2'b01, 1, 13'h032, 32'h0, LOAD_EXT ? 32'h000080F0 : LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[8]  = mk("lw_030",    1, 0, 2'b10, 0, 13'h030, 32'h0, LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[9]  = mk("lb_031",    1, 0, 2'b00, 0, 13'h031, 32'h0, LOAD_EXT ? 32'h0000007F : LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[10] = mk("lb_033",    1, 0, 2'b00, 0, 13'h033, 32'h0, LOAD_EXT ? 32'hFFFFFF80 : LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[11] = mk("lh_030",    1, 0, 2'b01, 0, 13'h030, 32'h0, LOAD_EXT ? 32'h00007F01 : LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[12] = mk("lsz3_030",  1, 0, 2'b11, 0, 13'h030, 32'h0, LD_WORD, 0, 0, 0, 32'h0, 13'h030);
    vecs[13] = mk("sw_mis021", 1, 1, 2'b10, 0, 13'h021, 32'h55555555, 32'h0, 0, 1, 0, 32'h0, 13'h020);
    vecs[14] = mk("lh_mis013", 1, 0, 2'b01, 0, 13'h013, 32'h0, 32'h0, 0, 1, 0, 32'h0, 13'h010);
    vecs[15] = mk("lw_mis032", 1, 0, 2'b10, 0, 13'h032, 32'h0, 32'h0, 0, 1, 0, 32'h0, 13'h030);
    vecs[16] = mk("sh_mis011", 1, 1, 2'b01, 0, 13'h011, 32'h0000BEEF, 32'h0, 0, 1, 0, 32'h0, 13'h010);
    vecs[17] = mk("idle",      0, 1, 2'b10, 0, 13'h1FFF, 32'h12345678, 32'h0, 0, 0, 0, 32'h0, 13'h1FFC);

    reset = 1'b0;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 13'h020, 32'hCAFEF00D);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_wr",    32'(bus.o_ram_wr), 32'd0);
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_addr",  32'(bus.o_ram_addr), 32'd0);
    chk("rst_wdata", bus.o_ram_wdata, 32'd0);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 13'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd);
      #1;
      chk({vecs[i].name, "_rdata"}, bus.o_rdata, vecs[i].e_rd);
      chk({vecs[i].name, "_stall"}, 32'(bus.o_stall), 32'(vecs[i].e_st));
      chk({vecs[i].name, "_mis"},   32'(bus.o_misalign), 32'(vecs[i].e_mis));
      chk({vecs[i].name, "_wr"},    32'(bus.o_ram_wr), 32'(vecs[i].e_wr));
      chk({vecs[i].name, "_raddr"}, 32'(bus.o_ram_addr), 32'(vecs[i].e_ra));
      if (vecs[i].e_wr) chk({vecs[i].name, "_wdata"}, bus.o_ram_wdata, vecs[i].e_wd);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 13'h0, 32'h0);
    #1;
    chk("mem_020_after_mis", mem[8], 32'hDEADBEEF);
    chk("mem_010_after_mis", mem[4], 32'hAABBCCDD);

    sub_store("sb_012", 2'b00, 13'h012, 32'hFFFFFF5A, 32'hAA5ACCDD, 1'b1);
    sw(13'h010, 32'hAABBCCDD);
    sub_store("sh_012", 2'b01, 13'h012, 32'hFFFF1234, 32'h1234CCDD, 1'b0);
    sw(13'h010, 32'hAABBCCDD);
    sub_store("sh_010", 2'b01, 13'h010, 32'h00001234, 32'hAABB1234, 1'b0);
    sw(13'h010, 32'hAABBCCDD);
    sub_store("sb_013", 2'b00, 13'h013, 32'h00000077, 32'h77BBCCDD, 1'b0);

    // Reset dropped while in MERGE must abort the pending write.
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 13'h00A, 32'h00000099);
    #1;
    chk("rstm_stall1", 32'(bus.o_stall), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstm_wr",    32'(bus.o_ram_wr), 32'd0);
    chk("rstm_stall", 32'(bus.o_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 13'h008, 32'h0);
    #1;
    chk("rstm_idle_stall", 32'(bus.o_stall), 32'd0);
    chk("rstm_idle_wr",    32'(bus.o_ram_wr), 32'd0);
    chk("rstm_lw",         bus.o_rdata, 32'h11223344);
    chk("rstm_mem",        mem[2], 32'h11223344);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 13'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
